// File: rtl/cla_seq_arbiter.sv
// cla_seq_arbiter
//   Shares one combinational 4-bit carry-lookahead adder slice between two
//   requesters. Each accepted operation is a WIDTH-bit add performed one
//   nibble per cycle, least-significant nibble first. The inter-nibble carry
//   lives in a register. Round-robin arbitration runs between the requesters.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational)
//   req{0,1}_a/_b/_ci          operands and carry-in
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     requester that owns the result
//   rsp_sum/rsp_co/rsp_ovf     sum, carry out of the MSB, signed overflow
//   busy                       operation in flight (RUN or DONE)
module cla_seq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic             prio;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic             grant0;
  logic             grant1;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       c;
  logic             c4;
  logic [3:0]       nib_sum;
  logic [WIDTH-1:0] sum_next;

  // Arbitration: a lone requester always wins; on contention the priority
  // pointer decides. Ready is forced low during reset so outputs read 0.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !prio);
    grant1     = req1_valid && (!req0_valid ||  prio);
    req0_ready = (state == IDLE) && !rst && grant0;
    req1_ready = (state == IDLE) && !rst && grant1;
  end

  // Select the current operand nibbles.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (k == KW'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice.
  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum = p ^ c;
  end

  // Result register with the current nibble replaced.
  always_comb begin
    sum_next = rsp_sum;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (k == KW'(i)) begin
        sum_next[4*i +: 4] = nib_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      prio      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
      rsp_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            if (req0_ready) begin
              a_reg  <= req0_a;
              b_reg  <= req0_b;
              carry  <= req0_ci;
              rsp_id <= 1'b0;
              prio   <= 1'b1;
            end else begin
              a_reg  <= req1_a;
              b_reg  <= req1_b;
              carry  <= req1_ci;
              rsp_id <= 1'b1;
              prio   <= 1'b0;
            end
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rsp_sum <= sum_next;
          carry   <= c4;
          if (k == KW'(NIB - 1)) begin
            rsp_co    <= c4;
            rsp_ovf   <= c[3] ^ c4;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_arbiter.sv
module tb_cla_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_ci;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_ci;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_co, rsp_ovf, busy;
  logic [15:0] rsp_sum;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  cla_seq_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [15:0] a, input logic [15:0] b, input logic ci);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ci = ci;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ci = ci;
    end
  endtask

  // Request, wait for grant, check latency; returns at the negedge where
  // rsp_valid is first seen high.
  task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b, input logic ci);
    int unsigned n;
    int unsigned lat;
    logic        rdy;
    @(negedge clk);
    drive(id, a, b, ci);
    #1;
    n   = 0;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = id ? req1_ready : req0_ready;
    end
    chk("grant", {63'd0, rdy}, 64'd1);
    chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("busy_run", {63'd0, busy}, 64'd1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
  endtask

  task automatic check_rsp(input logic id, input logic [15:0] s, input logic co, input logic ovf);
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rsp_id",    {63'd0, rsp_id},    {63'd0, id});
    chk("rsp_sum",   {48'd0, rsp_sum},   {48'd0, s});
    chk("rsp_co",    {63'd0, rsp_co},    {63'd0, co});
    chk("rsp_ovf",   {63'd0, rsp_ovf},   {63'd0, ovf});
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hs_valid_drop", {63'd0, rsp_valid}, 64'd0);
    chk("hs_busy_drop",  {63'd0, busy},      64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rci;
    logic [16:0] full;
    logic        rovf;
    logic        seen;
    logic        both_seen;
    int unsigned acc_n, rsp_n, last_acc;

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
    rsp_ready = 1'b0;

    // Reset state, including ready gated while a request is pending.
    #12;
    req0_valid = 1'b1;
    #1;
    chk("rst_outputs", {45'd0, rsp_valid, busy, rsp_id, rsp_co, rsp_ovf, rsp_sum},
        64'd0);
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic single op on requester 0.
    issue(1'b0, 16'h1234, 16'h0FED, 1'b0);
    check_rsp(1'b0, 16'h2221, 1'b0, 1'b0);
    chk("busy_done", {63'd0, busy}, 64'd1);
    handshake();

    // Wrap-around through the full carry chain, then signed overflow.
    issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check_rsp(1'b1, 16'h0000, 1'b1, 1'b0);
    handshake();
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    check_rsp(1'b0, 16'h8000, 1'b0, 1'b1);
    handshake();

    // Backpressure: DONE held with a competing request pending.
    issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
    check_rsp(1'b0, 16'h0100, 1'b0, 1'b0);
    drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_sum !== 16'h0100 || rsp_id !== 1'b0 ||
          req0_ready || req1_ready) seen = 1'b1;
    end
    chk("bp_hold", {63'd0, seen}, 64'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_accept_in_hs", {63'd0, req1_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("bp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    chk("bp_idle_ready", {63'd0, req1_ready}, 64'd1);
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    issue(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    check_rsp(1'b1, 16'h1000, 1'b0, 1'b0);
    handshake();

    // Reset on the second RUN cycle.
    @(negedge clk);
    drive(1'b0, 16'h1111, 16'h2222, 1'b0);
    #1;
    chk("mr_grant", {63'd0, req0_ready}, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mr_outputs", {45'd0, rsp_valid, busy, rsp_id, rsp_co, rsp_ovf, rsp_sum},
        64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("mr_no_stale", {63'd0, seen}, 64'd0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b1, 16'h4321, 16'h1111, 1'b1);
    #1;
    chk("mr_prio_restart", {62'd0, req0_ready, req1_ready}, 64'd2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    issue(1'b1, 16'h4321, 16'h1111, 1'b1);
    check_rsp(1'b1, 16'h5433, 1'b0, 1'b0);
    handshake();

    // Random operands against a reference sum.
    for (int i = 0; i < 150; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rci  = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + 17'(rci);
      rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      issue(1'(i), ra, rb, rci);
      check_rsp(1'(i), full[15:0], full[16], rovf);
      handshake();
    end

    // Both requesters held valid from reset: alternating grants.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 16'h0001, 16'h0002, 1'b0);
    drive(1'b1, 16'h1000, 16'h2000, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    both_seen = 1'b0;
    acc_n = 0;
    rsp_n = 0;
    last_acc = 0;
    for (int unsigned cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_seen = 1'b1;
      if (req0_ready || req1_ready) begin
        chk("arb_order", {63'd0, req1_ready}, 64'(acc_n % 2));
        if (acc_n > 0) chk("arb_spacing", 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
        acc_n++;
      end
      if (rsp_valid) begin
        chk("arb_rsp_id", {63'd0, rsp_id}, 64'(rsp_n % 2));
        chk("arb_rsp_sum", {48'd0, rsp_sum},
            (rsp_n % 2 == 0) ? 64'h0003 : 64'h3001);
        rsp_n++;
      end
      @(negedge clk);
    end
    chk("arb_never_both", {63'd0, both_seen}, 64'd0);
    chk("arb_accepts", 64'(acc_n), 64'd7);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
